// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, FSM state type and helpers for the keypad debouncer
package keypad_pkg;
    localparam int NUM_KEYS     = 10;
    localparam int DEF_DEBOUNCE = 16;
    localparam int DEF_REPEAT   = 1024;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    // true when more than one bit is set: clearing the lowest set bit leaves something
    function automatic logic multi_hot(input logic [NUM_KEYS-1:0] v);
        return |(v & (v - NUM_KEYS'(1)));
    endfunction
endpackage

// File: rtl/keypad_debounce10_sync2.sv
// sync2: parameterised-width two-flop synchroniser with synchronous reset
// Ports: clk, rst (sync, active-high), d (async input), q (synchronised output)
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/keypad_debounce10.sv
// keypad_debounce10: synchronise and debounce 10 key lines into a clean key vector, enable and press strobe
// Ports: clk, rst (sync, active-high), key_raw (async keys), key_out (accepted vector),
//        key_en (press held), key_valid (one-cycle press strobe), multi_err (more than one key accepted)
// Optional: KEYPAD_AUTOREPEAT_EN adds a key_valid pulse every REPEAT_CYCLES cycles while held
module keypad_debounce10
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
`ifdef KEYPAD_AUTOREPEAT_EN
    , parameter int REPEAT_CYCLES = DEF_REPEAT
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_out,
    output logic                key_en,
    output logic                key_valid,
    output logic                multi_err
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [NUM_KEYS-1:0] sync, sample, sample_n, out_n;
    logic                en_n, valid_n;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RLAST = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0] rpt;

    // held in RELEASE so a bounce back to PRESSED keeps the repeat phase
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || state == DEBOUNCE)
            rpt <= '0;
        else if (state == PRESSED)
            rpt <= (rpt == RLAST) ? '0 : rpt + RPT_W'(1);
    end
`endif

    sync2 #(.W(NUM_KEYS)) u_sync (.clk(clk), .rst(rst), .d(key_raw), .q(sync));

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sample_n = sample;
        out_n    = key_out;
        en_n     = key_en;
        valid_n  = 1'b0;
        case (state)
            IDLE: if (|sync) begin
                sample_n = sync;
                cnt_n    = CNT_W'(1);
                state_n  = DEBOUNCE;
            end
            DEBOUNCE: if (sync == sample) begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == LAST) begin
                    state_n = PRESSED;
                    out_n   = sample;
                    en_n    = 1'b1;
                    valid_n = 1'b1;
                end
            end else if (|sync) begin
                sample_n = sync;
                cnt_n    = CNT_W'(1);
            end else begin
                cnt_n   = '0;
                state_n = IDLE;
            end
            PRESSED: if (~|sync) begin
                cnt_n   = CNT_W'(1);
                state_n = RELEASE;
            end
            RELEASE: if (~|sync) begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    out_n   = '0;
                    en_n    = 1'b0;
                end
            end else begin
                cnt_n   = '0;
                state_n = PRESSED;
            end
            default: state_n = IDLE;
        endcase
`ifdef KEYPAD_AUTOREPEAT_EN
        if (state == PRESSED && rpt == RLAST)
            valid_n = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sample    <= '0;
            key_out   <= '0;
            key_en    <= 1'b0;
            key_valid <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sample    <= sample_n;
            key_out   <= out_n;
            key_en    <= en_n;
            key_valid <= valid_n;
            multi_err <= multi_hot(out_n);
        end
    end
endmodule
